uart_operand_rx: RTL and testbench

//  UART 8N1 receiver that is the operand-capture stage ahead of the 4-bit multiplier.

---
 rtl/uart_operand_rx.sv | 118 +++++++++++
 tb/tb_uart_operand_rx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_operand_rx.sv
// UART 8N1 receiver capturing two 4-bit multiplier operands per byte.
// Ports: clk, rst_n, rx in; a, b, op_valid, frame_err, busy out.
module uart_operand_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       op_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  state_t          state;
  logic            rx_m;
  logic            rx_s;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [7:0]      shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      a         <= '0;
      b         <= '0;
      op_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      op_valid  <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          // The detecting edge is count 0, so START begins at 1.
          if (!rx_s) begin
            state <= START;
            cnt   <= CW'(1);
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            idx <= '0;
            if (rx_s) state <= IDLE;
            else      state <= DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            shift <= {rx_s, shift[7:1]};
            idx   <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == FULL) begin
            cnt <= '0;
            if (rx_s) begin
              a        <= shift[3:0];
              b        <= shift[7:4];
              op_valid <= 1'b1;
              state    <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BRK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        BRK: begin
          cnt <= '0;
          // Held-low line: one error only, wait for idle.
          if (rx_s) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_operand_rx.sv
// Directed bench for uart_operand_rx at CLKS_PER_BIT=16.
// Checks operands, pulse counts/timing, breaks, reset and random bytes.
module tb_uart_operand_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [3:0] a;
  logic [3:0] b;
  logic       op_valid;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nv    = 0;
  int nf    = 0;
  int both  = 0;
  int ov_cyc = -1;
  logic [3:0] la [0:511];
  logic [3:0] lb [0:511];
  logic [7:0] exp_q [$];

  uart_operand_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .a(a),
    .b(b),
    .op_valid(op_valid),
    .frame_err(frame_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (op_valid) begin
      if (nv < 512) begin
        la[nv] = a;
        lb[nv] = b;
      end
      nv = nv + 1;
      ov_cyc = cyc;
    end
    if (frame_err) nf = nf + 1;
    if (op_valid && frame_err) both = both + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cyc(CPB);
    end
    rx = stop_bit;
    wait_cyc(CPB);
  endtask

  initial begin
    int t0;
    int nv0;
    int nf0;
    logic [7:0] d;
    rx    = 1'b1;
    rst_n = 1'b0;
    wait_cyc(3);
    chk("rst_a", a, 4'h0);
    chk("rst_b", b, 4'h0);
    chk("rst_ov", op_valid, 1'b0);
    chk("rst_fe", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    wait_cyc(4);

    // 0x3B with timing of the op_valid pulse
    nv0 = nv;
    t0  = cyc;
    send(8'h3B, 1'b1);
    wait_cyc(4);
    chk("3b_nv", nv - nv0, 1);
    chk("3b_cyc", ov_cyc - t0, 154);
    chk("3b_a", a, 4'hB);
    chk("3b_b", b, 4'h3);
    chk("3b_prod", a * b, 8'h21);
    chk("3b_fe", nf, 0);

    // false start
    nv0 = nv;
    rx  = 1'b0;
    wait_cyc(4);
    rx  = 1'b1;
    chk("fs_busy1", busy, 1'b1);
    wait_cyc(10);
    chk("fs_busy0", busy, 1'b0);
    wait_cyc(2 * CPB);
    chk("fs_nv", nv - nv0, 0);
    chk("fs_fe", nf, 0);
    chk("fs_a", a, 4'hB);
    chk("fs_b", b, 4'h3);

    // framing error then break
    nv0 = nv;
    send(8'h5A, 1'b0);
    wait_cyc(40 * CPB);
    chk("fe_nf", nf, 1);
    chk("fe_nv", nv - nv0, 0);
    chk("fe_a", a, 4'hB);
    chk("fe_b", b, 4'h3);
    chk("fe_busy", busy, 1'b1);
    rx = 1'b1;
    wait_cyc(2 * CPB);
    chk("fe_idle", busy, 1'b0);
    send(8'hFF, 1'b1);
    wait_cyc(4);
    chk("ff_nv", nv - nv0, 1);
    chk("ff_a", a, 4'hF);
    chk("ff_b", b, 4'hF);
    chk("ff_nf", nf, 1);

    // back-to-back frames, single stop bit
    nv0 = nv;
    send(8'h00, 1'b1);
    send(8'hA7, 1'b1);
    wait_cyc(4);
    chk("bb_nv", nv - nv0, 2);
    chk("bb_a0", la[nv0], 4'h0);
    chk("bb_b0", lb[nv0], 4'h0);
    chk("bb_a1", la[nv0 + 1], 4'h7);
    chk("bb_b1", lb[nv0 + 1], 4'hA);

    // reset during data bit 4 of 0xC3
    d  = 8'hC3;
    rx = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      wait_cyc(CPB);
    end
    rx = d[4];
    wait_cyc(CPB / 2);
    nv0 = nv;
    nf0 = nf;
    rst_n = 1'b0;
    #1;
    chk("mr_a", a, 4'h0);
    chk("mr_b", b, 4'h0);
    chk("mr_ov", op_valid, 1'b0);
    chk("mr_fe", frame_err, 1'b0);
    chk("mr_busy", busy, 1'b0);
    rx = 1'b1;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(2 * CPB);
    chk("mr_nv", nv - nv0, 0);
    chk("mr_nf", nf - nf0, 0);
    send(8'h12, 1'b1);
    wait_cyc(4);
    chk("12_nv", nv - nv0, 1);
    chk("12_a", a, 4'h2);
    chk("12_b", b, 4'h1);

    // random bytes
    nv0 = nv;
    nf0 = nf;
    for (int i = 0; i < 200; i++) begin
      d = 8'($urandom_range(255));
      exp_q.push_back(d);
      send(d, 1'b1);
    end
    wait_cyc(4);
    chk("rnd_nv", nv - nv0, 200);
    chk("rnd_nf", nf - nf0, 0);
    for (int i = 0; i < 200; i++) begin
      if (nv0 + i < 512 && i < exp_q.size()) begin
        chk("rnd_a", la[nv0 + i], exp_q[i][3:0]);
        chk("rnd_b", lb[nv0 + i], exp_q[i][7:4]);
      end
    end
    chk("no_overlap", both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
